// File: rtl/common.sv
// rtl/common.sv - shared constants, pipeline-register types and ALU helpers for risc_v_core
package common;
    localparam logic        RESET = 1'b1;
    localparam logic [31:0] NOOP  = 32'h00000013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    localparam logic [2:0] F3_WORD = 3'd2;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_t;
    typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} b_sel_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        alu_op_t     alu_op;
        a_sel_t      a_sel;
        b_sel_t      b_sel;
        logic [2:0]  funct3;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_wb_t;

    function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt, input logic is_reg);
        case (f3)
            3'd0:    return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a + b;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            F3_BEQ:  return a == b;
            F3_BNE:  return a != b;
            F3_BLT:  return $signed(a) < $signed(b);
            F3_BGE:  return $signed(a) >= $signed(b);
            F3_BLTU: return a < b;
            F3_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/if_stage.sv
// rtl/if_stage.sv - program counter and halfword instruction memory fetch
module instruction_memory (
    input  logic [5:0]  addr0,
    input  logic [5:0]  addr1,
    output logic [15:0] data0,
    output logic [15:0] data1
);
    logic [15:0] ram [0:63];

    assign data0 = ram[addr0];
    assign data1 = ram[addr1];
endmodule

module if_stage
    import common::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] target,
    output if_id_t      fetched
);
    logic [31:0] pc;
    logic [5:0]  idx;
    logic [5:0]  idx_next;
    logic [15:0] half_lo;
    logic [15:0] half_hi;
    logic        wide;

    assign idx      = pc[6:1];
    assign idx_next = idx + 6'd1;

    instruction_memory instruction_memory (
        .addr0 (idx),
        .addr1 (idx_next),
        .data0 (half_lo),
        .data1 (half_hi)
    );

    // Only halfwords tagged 2'b11 start a 32-bit instruction; anything else is a 2-byte NOP.
    assign wide          = (half_lo[1:0] == 2'b11);
    assign fetched.pc    = pc;
    assign fetched.instr = wide ? {half_hi, half_lo} : NOOP;

    always_ff @(posedge clk) begin
        if (rst == RESET)
            pc <= 32'd0;
        else if (redirect)
            pc <= target;
        else if (!stall)
            pc <= pc + (wide ? 32'd4 : 32'd2);
    end
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - word-addressed data memory access for loads and stores
module data_memory #(
    parameter int ADDRESS_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [31:0]              write_data,
    output logic [31:0]              read_data
);
    logic [31:0] ram [0:(1<<ADDRESS_WIDTH)-1];

    assign read_data = ram[addr];

    always_ff @(posedge clk) begin
        if (write_enable)
            ram[addr] <= write_data;
    end
endmodule

module mem_stage
    import common::*;
#(
    parameter int DATA_ADDRESS_WIDTH = 6
) (
    input  logic    clk,
    input  ex_mem_t ex_mem,
    output mem_wb_t mem_result
);
    logic [31:0] read_data;

    // Byte-offset bits are dropped and high address bits wrap onto the small memory.
    data_memory #(.ADDRESS_WIDTH(DATA_ADDRESS_WIDTH)) data_memory (
        .clk          (clk),
        .write_enable (ex_mem.mem_write),
        .addr         (ex_mem.alu_result[DATA_ADDRESS_WIDTH+1:2]),
        .write_data   (ex_mem.store_data),
        .read_data    (read_data)
    );

    assign mem_result.result    = ex_mem.mem_read ? read_data : ex_mem.alu_result;
    assign mem_result.rd        = ex_mem.rd;
    assign mem_result.reg_write = ex_mem.reg_write;
endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32-entry register file, x0 hard zero, write-before-read bypass
module register_file #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] rs1_addr,
    input  logic [ADDRESS_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0]    rs1_data,
    output logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0]    write_data
);
    import common::*;

    logic [DATA_WIDTH-1:0] registers [0:(1<<ADDRESS_WIDTH)-1];

    always_comb begin
        rs1_data = registers[rs1_addr];
        rs2_data = registers[rs2_addr];
        if (write_enable && write_addr == rs1_addr) rs1_data = write_data;
        if (write_enable && write_addr == rs2_addr) rs2_data = write_data;
        if (rs1_addr == '0) rs1_data = '0;
        if (rs2_addr == '0) rs2_data = '0;
    end

    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            for (int i = 0; i < (1 << ADDRESS_WIDTH); i++)
                registers[i] <= '0;
        end else if (write_enable && write_addr != '0) begin
            registers[write_addr] <= write_data;
        end
    end
endmodule

// File: rtl/risc_v_core.sv
// rtl/risc_v_core.sv - five-stage RV32I pipeline top with decode, forwarding and hazard control
module risc_v_core
    import common::*;
#(
    parameter int DATA_ADDRESS_WIDTH          = 6,
    parameter int CPU_DATA_WIDTH              = 32,
    parameter int REGISTER_FILE_ADDRESS_WIDTH = 5
) (
    input logic clk,
    input logic rst
);
    if_id_t      fetched, if_id;
    id_ex_t      decoded, id_ex;
    ex_mem_t     ex_next, ex_mem;
    mem_wb_t     mem_next, mem_wb;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] fwd_a, fwd_b, op_a, op_b, target;
    logic        uses_rs1, uses_rs2, stall, redirect;

    if_stage if_stage (
        .clk (clk), .rst (rst), .stall (stall), .redirect (redirect),
        .target (target), .fetched (fetched)
    );

    register_file #(
        .ADDRESS_WIDTH (REGISTER_FILE_ADDRESS_WIDTH),
        .DATA_WIDTH    (CPU_DATA_WIDTH)
    ) register_file (
        .clk (clk), .rst (rst),
        .rs1_addr (if_id.instr[19:15]), .rs2_addr (if_id.instr[24:20]),
        .rs1_data (rs1_data), .rs2_data (rs2_data),
        .write_enable (mem_wb.reg_write), .write_addr (mem_wb.rd), .write_data (mem_wb.result)
    );

    mem_stage #(.DATA_ADDRESS_WIDTH(DATA_ADDRESS_WIDTH)) mem_stage (
        .clk (clk), .ex_mem (ex_mem), .mem_result (mem_next)
    );

    always_comb begin
        decoded         = '0;
        decoded.pc      = if_id.pc;
        decoded.rs1_val = rs1_data;
        decoded.rs2_val = rs2_data;
        decoded.rs1     = if_id.instr[19:15];
        decoded.rs2     = if_id.instr[24:20];
        decoded.rd      = if_id.instr[11:7];
        decoded.funct3  = if_id.instr[14:12];
        decoded.alu_op  = ALU_ADD;
        decoded.a_sel   = A_RS1;
        decoded.b_sel   = B_IMM;
        decoded.imm     = {{20{if_id.instr[31]}}, if_id.instr[31:20]};
        uses_rs1        = 1'b0;
        uses_rs2        = 1'b0;
        case (if_id.instr[6:0])
            OP_LUI, OP_AUIPC: begin
                decoded.imm       = {if_id.instr[31:12], 12'd0};
                decoded.a_sel     = (if_id.instr[6:0] == OP_LUI) ? A_ZERO : A_PC;
                decoded.reg_write = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                if (if_id.instr[6:0] == OP_JAL)
                    decoded.imm = {{11{if_id.instr[31]}}, if_id.instr[31], if_id.instr[19:12],
                                   if_id.instr[20], if_id.instr[30:21], 1'b0};
                decoded.a_sel     = A_PC;
                decoded.b_sel     = B_FOUR;
                decoded.reg_write = 1'b1;
                decoded.jump      = 1'b1;
                decoded.jalr      = (if_id.instr[6:0] == OP_JALR);
                uses_rs1          = decoded.jalr;
            end
            OP_BRANCH: begin
                decoded.imm    = {{19{if_id.instr[31]}}, if_id.instr[31], if_id.instr[7],
                                  if_id.instr[30:25], if_id.instr[11:8], 1'b0};
                decoded.branch = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OP_LOAD: if (if_id.instr[14:12] == F3_WORD) begin
                decoded.mem_read  = 1'b1;
                decoded.reg_write = 1'b1;
                uses_rs1          = 1'b1;
            end
            OP_STORE: if (if_id.instr[14:12] == F3_WORD) begin
                decoded.imm       = {{20{if_id.instr[31]}}, if_id.instr[31:25], if_id.instr[11:7]};
                decoded.mem_write = 1'b1;
                uses_rs1          = 1'b1;
                uses_rs2          = 1'b1;
            end
            OP_IMM, OP_REG: begin
                decoded.alu_op    = alu_decode(if_id.instr[14:12], if_id.instr[30], if_id.instr[6:0] == OP_REG);
                decoded.b_sel     = (if_id.instr[6:0] == OP_REG) ? B_RS2 : B_IMM;
                decoded.reg_write = 1'b1;
                uses_rs1          = 1'b1;
                uses_rs2          = (if_id.instr[6:0] == OP_REG);
            end
            default: ;
        endcase
    end

    // A load result only exists after MEM, so a dependent instruction waits one cycle in ID.
    assign stall = id_ex.mem_read && id_ex.rd != 5'd0 &&
                   ((uses_rs1 && decoded.rs1 == id_ex.rd) || (uses_rs2 && decoded.rs2 == id_ex.rd));

    always_comb begin
        fwd_a = id_ex.rs1_val;
        if (id_ex.rs1 != 5'd0 && ex_mem.reg_write && ex_mem.rd == id_ex.rs1)
            fwd_a = ex_mem.alu_result;
        else if (id_ex.rs1 != 5'd0 && mem_wb.reg_write && mem_wb.rd == id_ex.rs1)
            fwd_a = mem_wb.result;
        fwd_b = id_ex.rs2_val;
        if (id_ex.rs2 != 5'd0 && ex_mem.reg_write && ex_mem.rd == id_ex.rs2)
            fwd_b = ex_mem.alu_result;
        else if (id_ex.rs2 != 5'd0 && mem_wb.reg_write && mem_wb.rd == id_ex.rs2)
            fwd_b = mem_wb.result;
    end

    always_comb begin
        case (id_ex.a_sel)
            A_RS1:   op_a = fwd_a;
            A_PC:    op_a = id_ex.pc;
            default: op_a = 32'd0;
        endcase
        case (id_ex.b_sel)
            B_RS2:   op_b = fwd_b;
            B_IMM:   op_b = id_ex.imm;
            default: op_b = 32'd4;
        endcase
        ex_next.alu_result = alu(id_ex.alu_op, op_a, op_b);
        ex_next.store_data = fwd_b;
        ex_next.rd         = id_ex.rd;
        ex_next.reg_write  = id_ex.reg_write;
        ex_next.mem_read   = id_ex.mem_read;
        ex_next.mem_write  = id_ex.mem_write;
        redirect = id_ex.jump || (id_ex.branch && branch_taken(id_ex.funct3, fwd_a, fwd_b));
        target   = id_ex.jalr ? ((fwd_a + id_ex.imm) & ~32'd1) : (id_ex.pc + id_ex.imm);
    end

    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            if_id  <= '{pc: 32'd0, instr: NOOP};
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            if (redirect)
                if_id <= '{pc: 32'd0, instr: NOOP};
            else if (!stall)
                if_id <= fetched;
            if (redirect || stall)
                id_ex <= '0;
            else
                id_ex <= decoded;
            ex_mem <= ex_next;
            mem_wb <= mem_next;
        end
    end
endmodule

// File: tb/tb_risc_v_core.sv
// tb/tb_risc_v_core.sv - directed programs checked against an instruction-level reference model
module tb_risc_v_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [15:0] img   [64];
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [64];
    logic [31:0] prog  [$];

    risc_v_core #(
        .DATA_ADDRESS_WIDTH (6),
        .CPU_DATA_WIDTH (32),
        .REGISTER_FILE_ADDRESS_WIDTH (5)
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] i_type(logic [6:0] op, int f3, int rd, int rs1, int imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] r_type(int f7, int f3, int rd, int rs1, int rs2);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] sw(int rs2, int rs1, int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] br(int f3, int rs1, int rs2, int off);
        return {off[12], off[10:5], rs2[4:0], rs1[4:0], f3[2:0], off[4:1], off[11], 7'h63};
    endfunction
    function automatic logic [31:0] u_type(logic [6:0] op, int rd, int imm);
        return {imm[19:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] jal(int rd, int off);
        return {off[20], off[10:1], off[11], off[19:12], rd[4:0], 7'h6f};
    endfunction
    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return i_type(7'h13, 0, rd, rs1, imm);
    endfunction

    // Reference: architectural interpreter, one instruction per step, stops at the self-loop.
    task automatic run_model();
        logic [31:0] pc, ins, a, b, res, nxt, addr, i_imm;
        logic        wr;
        int          h, steps;
        for (int r = 0; r < 32; r++) m_reg[r] = 32'd0;
        pc = 32'd0;
        steps = 0;
        while (pc != 32'd124 && steps < 2000) begin
            steps++;
            h = int'(pc / 2) % 64;
            if (img[h][1:0] != 2'b11) begin
                pc = pc + 2;
                continue;
            end
            ins   = {img[(h + 1) % 64], img[h]};
            a     = m_reg[ins[19:15]];
            b     = m_reg[ins[24:20]];
            i_imm = 32'($signed(ins[31:20]));
            nxt   = pc + 4;
            res   = 32'd0;
            wr    = 1'b0;
            case (ins[6:0])
                7'h37: begin res = {ins[31:12], 12'd0}; wr = 1'b1; end
                7'h17: begin res = pc + {ins[31:12], 12'd0}; wr = 1'b1; end
                7'h6f: begin
                    res = pc + 4; wr = 1'b1;
                    nxt = pc + 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                end
                7'h67: begin res = pc + 4; wr = 1'b1; nxt = (a + i_imm) & 32'hFFFF_FFFE; end
                7'h63: begin
                    logic tk;
                    case (ins[14:12])
                        3'd0: tk = (a == b);
                        3'd1: tk = (a != b);
                        3'd4: tk = ($signed(a) < $signed(b));
                        3'd5: tk = ($signed(a) >= $signed(b));
                        3'd6: tk = (a < b);
                        3'd7: tk = (a >= b);
                        default: tk = 1'b0;
                    endcase
                    if (tk) nxt = pc + 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                end
                7'h03: if (ins[14:12] == 3'd2) begin
                    addr = a + i_imm;
                    res = m_mem[(addr / 4) % 64]; wr = 1'b1;
                end
                7'h23: if (ins[14:12] == 3'd2) begin
                    addr = a + 32'($signed({ins[31:25], ins[11:7]}));
                    m_mem[(addr / 4) % 64] = b;
                end
                7'h13, 7'h33: begin
                    if (ins[6:0] == 7'h13) b = i_imm;
                    wr = 1'b1;
                    case (ins[14:12])
                        3'd0: res = (ins[6:0] == 7'h33 && ins[30]) ? a - b : a + b;
                        3'd1: res = a << (b % 32);
                        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd3: res = (a < b) ? 32'd1 : 32'd0;
                        3'd4: res = a ^ b;
                        3'd5: res = ins[30] ? 32'($signed(a) >>> (b % 32)) : a >> (b % 32);
                        3'd6: res = a | b;
                        default: res = a & b;
                    endcase
                end
                default: ;
            endcase
            if (wr && ins[11:7] != 5'd0) m_reg[ins[11:7]] = res;
            pc = nxt;
        end
        check("model_reaches_self_loop", pc, 32'd124);
    endtask

    task automatic load_program();
        for (int i = 0; i < 64; i++) img[i] = 16'h0000;
        foreach (prog[i]) begin
            img[2*i]   = prog[i][15:0];
            img[2*i+1] = prog[i][31:16];
        end
        img[62] = 16'h0063;
        img[63] = 16'h0000;
        for (int i = 0; i < 64; i++) begin
            dut.if_stage.instruction_memory.ram[i] = img[i];
            dut.mem_stage.data_memory.ram[i] = 32'd0;
            m_mem[i] = 32'd0;
        end
    endtask

    task automatic compare_state(input string tag);
        for (int r = 0; r < 32; r++)
            check($sformatf("%s_x%0d", tag, r), dut.register_file.registers[r], m_reg[r]);
        for (int m = 0; m < 64; m++)
            check($sformatf("%s_mem%0d", tag, m), dut.mem_stage.data_memory.ram[m], m_mem[m]);
    endtask

    task automatic run_program(input string tag);
        rst = 1'b1;
        @(negedge clk);
        load_program();
        run_model();
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        compare_state(tag);
    endtask

    initial begin
        // Program 1: forwarding, store/load, load-use, LUI, x0 writes, ALU ops, address wrap.
        prog = '{addi(1, 0, 5), addi(2, 1, 7), addi(3, 0, 42), sw(3, 0, 8), i_type(7'h03, 2, 4, 0, 8),
                 r_type(0, 0, 5, 4, 4), u_type(7'h37, 7, 'h12345), addi(7, 7, 'h678), addi(0, 0, 9),
                 r_type('h20, 0, 8, 1, 2), i_type(7'h13, 5, 9, 8, 1025), i_type(7'h13, 5, 10, 8, 28),
                 i_type(7'h13, 4, 11, 1, -1), r_type(0, 3, 12, 1, 8), r_type(0, 1, 13, 1, 1),
                 sw(5, 0, -4), sw(7, 0, 46), i_type(7'h03, 2, 14, 0, 44)};
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_pc", dut.if_stage.pc, 32'd0);
        check("reset_if_id_instr", dut.if_id.instr, 32'h00000013);
        check("reset_id_ex_write", {31'd0, dut.id_ex.reg_write}, 32'd0);
        check("reset_x1", dut.register_file.registers[1], 32'd0);
        run_program("p1");
        check("p1_x1", dut.register_file.registers[1], 32'd5);
        check("p1_x2", dut.register_file.registers[2], 32'd12);
        check("p1_x4", dut.register_file.registers[4], 32'd42);
        check("p1_x5", dut.register_file.registers[5], 32'd84);
        check("p1_x7", dut.register_file.registers[7], 32'h12345678);
        check("p1_x0", dut.register_file.registers[0], 32'd0);
        check("p1_x8", dut.register_file.registers[8], 32'hFFFFFFF9);
        check("p1_x9", dut.register_file.registers[9], 32'hFFFFFFFC);
        check("p1_x10", dut.register_file.registers[10], 32'h0000000F);
        check("p1_x11", dut.register_file.registers[11], 32'hFFFFFFFA);
        check("p1_x12", dut.register_file.registers[12], 32'd1);
        check("p1_x13", dut.register_file.registers[13], 32'd160);
        check("p1_x14", dut.register_file.registers[14], 32'h12345678);
        check("p1_mem2", dut.mem_stage.data_memory.ram[2], 32'd42);
        check("p1_mem11", dut.mem_stage.data_memory.ram[11], 32'h12345678);
        check("p1_mem63", dut.mem_stage.data_memory.ram[63], 32'd84);
        check("model_x5", m_reg[5], 32'd84);
        check("model_x14", m_reg[14], 32'h12345678);

        // Mid-run reset: restart, interrupt after a few cycles, memory must survive.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_pc", dut.if_stage.pc, 32'd0);
        for (int r = 0; r < 32; r++)
            check($sformatf("midreset_x%0d", r), dut.register_file.registers[r], 32'd0);
        check("midreset_mem2", dut.mem_stage.data_memory.ram[2], 32'd42);
        check("midreset_mem63", dut.mem_stage.data_memory.ram[63], 32'd84);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        compare_state("p1_rerun");

        // Program 2: branch taken / not-taken cases.
        prog = '{addi(1, 0, -1), addi(2, 0, 1), br(0, 0, 0, 8), addi(6, 0, 1), br(1, 1, 2, 8),
                 addi(7, 0, 1), br(4, 1, 2, 8), addi(8, 0, 1), br(6, 1, 2, 8), addi(9, 0, 1),
                 br(5, 1, 2, 8), addi(10, 0, 2), br(7, 1, 2, 8), addi(11, 0, 3), addi(12, 0, 4)};
        run_program("p2");
        check("p2_beq_skip_x6", dut.register_file.registers[6], 32'd0);
        check("p2_bne_skip_x7", dut.register_file.registers[7], 32'd0);
        check("p2_blt_skip_x8", dut.register_file.registers[8], 32'd0);
        check("p2_bltu_fall_x9", dut.register_file.registers[9], 32'd1);
        check("p2_bge_fall_x10", dut.register_file.registers[10], 32'd2);
        check("p2_bgeu_skip_x11", dut.register_file.registers[11], 32'd0);
        check("p2_x12", dut.register_file.registers[12], 32'd4);

        // Program 3: JAL, JALR back to PC 4, AUIPC.
        prog = '{jal(1, 8), addi(5, 0, 7), addi(6, 6, 1), br(1, 5, 0, 8),
                 i_type(7'h67, 0, 0, 1, 0), u_type(7'h17, 10, 1), addi(11, 1, 0)};
        run_program("p3");
        check("p3_link_x1", dut.register_file.registers[1], 32'd4);
        check("p3_x5", dut.register_file.registers[5], 32'd7);
        check("p3_count_x6", dut.register_file.registers[6], 32'd2);
        check("p3_auipc_x10", dut.register_file.registers[10], 32'h00001014);
        check("model_x6", m_reg[6], 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/risc_v_core.md
# risc_v_core

Minimal in-order RV32I processor core: five-stage pipeline (IF, ID, EX, MEM, WB) with private instruction memory, 32-entry register file and word-addressed data memory. It is the top of the CPU design. The only pins are clock and reset; program and results are loaded and inspected hierarchically by the bench. Top module name: risc_v_core.

## Interface
- DATA_ADDRESS_WIDTH, 6: data memory word-address bits (64 words).
- CPU_DATA_WIDTH, 32: datapath and register width.
- REGISTER_FILE_ADDRESS_WIDTH, 5: register index bits (32 registers).
- clk  input  1  sole clock, all state on rising edge.
- rst  input  1  reset; synchronous, active-high (asserted level = package constant RESET = 1'b1).

## Operation
- Required hierarchy, accessed by bench:
  - if_stage.instruction_memory.ram: 64 x 16-bit halfwords, no write port, no reset.
  - register_file.registers: 32 x CPU_DATA_WIDTH.
  - mem_stage.data_memory.ram: 2^DATA_ADDRESS_WIDTH x 32, zero at time 0, not cleared by reset.
- Fetch: PC is a byte address; halfword index = PC[6:1], wraps modulo 128 bytes.
  - If ram[PC/2][1:0] == 2'b11: 32-bit instruction = {ram[PC/2+1], ram[PC/2]}; PC += 4.
  - Otherwise the halfword is a NOP; PC += 2. All-zero memory therefore executes as NOPs.
- Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
- Any other opcode executes as a NOP; there are no traps.
- x0 always reads 0; writes to x0 are discarded.
- Data memory word index = effective address[DATA_ADDRESS_WIDTH+1:2]; the low two address bits are ignored; upper bits wrap.
- NOOP constant = 32'h00000013 (ADDI x0,x0,0); it is inserted into flushed or stalled pipeline slots.
- Arithmetic: 32-bit wrap-around; shifts use rs2/shamt[4:0].

## Timing
- Reset (rst=1 at a rising edge):
  - PC = 0; all pipeline registers hold NOOP with writes disabled; all registers = 0.
  - Memories are unchanged.
  - Mid-program reset restarts at PC 0 on the next cycle.
- Ideal throughput: 1 instruction per cycle; latency from fetch to register writeback is 5 cycles.
- Forwarding: EX/MEM and MEM/WB results forward to EX operands. EX/MEM has priority over MEM/WB; no forwarding for x0.
- Register file: write in WB, read in ID with write-before-read bypass, so a same-cycle WB value is seen in ID.
- Load-use: when ID needs rd of a LW currently in EX, stall IF/ID for 1 cycle and inject a bubble into EX.
- Branches and jumps resolve in EX. When taken: redirect PC, flush IF/ID and ID/EX (2-cycle penalty). Not-taken branches cost no penalty.
- SW writes data memory at the rising edge at the end of MEM. LW data is read combinationally in MEM and registered into MEM/WB.
- Self-loop BEQ x0,x0,0 (halfwords 62/63 = 16'h0063, 16'h0000) holds the core stable indefinitely.

## Structure
- Shared package common holds:
  - RESET, NOOP, opcode/funct3 constants, ALU-op enum.
  - Pipeline-register struct typedefs.
- Sub-modules:
  - if_stage, containing instruction_memory.
  - register_file.
  - mem_stage, containing data_memory.
  - ID/EX logic and hazard unit inline in the top.

## Test plan
- ADDI x1,x0,5; ADDI x2,x1,7 (back-to-back) -> x1=5, x2=12 via forwarding.
- ADDI x3,x0,42; SW x3,8(x0); LW x4,8(x0); ADD x5,x4,x4 -> ram[2]=42, x4=42, x5=84 (load-use stall).
- BEQ x0,x0,+8 skipping ADDI x6,x0,1 -> x6=0; BNE with unequal operands taken; BLT -1 vs 1 taken; BLTU 0xFFFFFFFF vs 1 not taken.
- JAL x1,+8 from PC 0 -> x1=4, skipped instruction has no effect; JALR x0,0(x1) jumps to PC 4.
- LUI x7,0x12345; ADDI x7,x7,0x678 -> x7=0x12345678. ADDI x0,x0,9 -> x0 stays 0.
- Program followed by NOP fill and final self-loop; after 200 cycles -> all registers/memory match expected; reset asserted mid-run -> PC=0, registers cleared, memory retained.
